// File: rtl/aes_gcm_feeder.sv
// rtl/aes_gcm_feeder.sv - AES-GCM upstream sequencer: pads AAD/payload beats, issues blocks, then drives the length block
module aes_gcm_feeder #(
    parameter int LEN_W = 61
) (
    input  logic           iClk,
    input  logic           iRstn,
    input  logic           iStart,
    input  logic [0:127]   iIn,
    input  logic [4:0]     iInBytes,
    input  logic           iInAad,
    input  logic           iInLast,
    input  logic           iInValid,
    output logic           oInReady,
    output logic           oInit,
    input  logic           iCoreReady,
    input  logic           iCoreResultValid,
    input  logic           iCoreTagValid,
    output logic [0:127]   oAad,
    output logic           oAad_valid,
    output logic           oAad_last,
    output logic [0:127]   oBlock,
    output logic           oBlock_valid,
    output logic           oBlock_last,
    output logic           oBusy
);

    typedef enum logic [2:0] {
        S_IDLE, S_HKEY, S_HKEY_WAIT, S_AAD, S_DATA_ISSUE, S_DATA_PULSE, S_DATA_WAIT, S_LEN
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   lena_q, lena_d, lenc_q, lenc_d;
    logic [0:127]       aad_q, aad_d, block_q, block_d;
    logic               aad_valid_q, aad_valid_d, aad_last_q, aad_last_d;
    logic               block_valid_q, block_valid_d, block_last_q, block_last_d;
    logic               in_ready, accept;
    logic [4:0]         nb;
    logic [0:127]       padded;
    logic [0:127]       len_block;

    function automatic logic [0:127] pad_beat(input logic [0:127] d, input logic [4:0] n);
        logic [0:127] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) < n) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        nb        = (iInBytes > 5'd16) ? 5'd16 : iInBytes;
        padded    = pad_beat(iIn, nb);
        len_block = {64'({lena_q, 3'b000}), 64'({lenc_q, 3'b000})};
        // A beat tagged for the other section is never taken, so it cannot corrupt the counters
        case (state_q)
            S_AAD:        in_ready = iCoreReady & iInAad;
            S_DATA_ISSUE: in_ready = ~iInAad;
            default:      in_ready = 1'b0;
        endcase
        accept = iInValid & in_ready;
    end

    always_comb begin
        state_d       = state_q;
        lena_d        = lena_q;
        lenc_d        = lenc_q;
        aad_d         = aad_q;
        aad_valid_d   = 1'b0;
        aad_last_d    = 1'b0;
        block_d       = block_q;
        block_valid_d = 1'b0;
        block_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_HKEY;
                    lena_d  = '0;
                    lenc_d  = '0;
                end
            end
            S_HKEY:      state_d = S_HKEY_WAIT;
            S_HKEY_WAIT: if (iCoreReady) state_d = S_AAD;
            S_AAD: begin
                if (accept) begin
                    lena_d      = lena_q + LEN_W'(nb);
                    aad_d       = padded;
                    aad_valid_d = (nb != 5'd0);
                    aad_last_d  = iInLast;
                    if (iInLast) state_d = S_DATA_ISSUE;
                end
            end
            S_DATA_ISSUE: begin
                if (accept) begin
                    lenc_d       = lenc_q + LEN_W'(nb);
                    block_d      = padded;
                    block_last_d = iInLast;
                    if (nb != 5'd0) begin
                        block_valid_d = 1'b1;
                        state_d       = S_DATA_PULSE;
                    end else if (iInLast) begin
                        state_d = S_LEN;
                    end
                end
            end
            S_DATA_PULSE: begin
                block_last_d = block_last_q;
                state_d      = S_DATA_WAIT;
            end
            S_DATA_WAIT: begin
                // block_last_q doubles as the "final payload block" flag
                if (iCoreResultValid) state_d = block_last_q ? S_LEN : S_DATA_ISSUE;
                else                  block_last_d = block_last_q;
            end
            S_LEN:   if (iCoreTagValid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            state_q       <= S_IDLE;
            lena_q        <= '0;
            lenc_q        <= '0;
            aad_q         <= '0;
            aad_valid_q   <= 1'b0;
            aad_last_q    <= 1'b0;
            block_q       <= '0;
            block_valid_q <= 1'b0;
            block_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lena_q        <= lena_d;
            lenc_q        <= lenc_d;
            aad_q         <= aad_d;
            aad_valid_q   <= aad_valid_d;
            aad_last_q    <= aad_last_d;
            block_q       <= block_d;
            block_valid_q <= block_valid_d;
            block_last_q  <= block_last_d;
        end
    end

    assign oInReady     = in_ready;
    assign oInit        = (state_q != S_IDLE);
    assign oBusy        = (state_q != S_IDLE);
    assign oAad         = (state_q == S_LEN) ? len_block : aad_q;
    assign oAad_valid   = aad_valid_q;
    assign oAad_last    = aad_last_q;
    assign oBlock       = block_q;
    assign oBlock_valid = block_valid_q;
    assign oBlock_last  = block_last_q;

endmodule

// File: tb/tb_aes_gcm_feeder.sv
// tb/tb_aes_gcm_feeder.sv - directed and randomized bench for aes_gcm_feeder against a section-level model
module tb_aes_gcm_feeder;

    logic         iClk = 1'b0;
    logic         iRstn, iStart, iInAad, iInLast, iInValid;
    logic [0:127] iIn;
    logic [4:0]   iInBytes;
    logic         iCoreReady, iCoreResultValid, iCoreTagValid;
    logic         oInReady, oInit, oAad_valid, oAad_last, oBlock_valid, oBlock_last, oBusy;
    logic [0:127] oAad, oBlock;

    int checks = 0;
    int failures = 0;

    aes_gcm_feeder #(.LEN_W(61)) dut (
        .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iIn(iIn), .iInBytes(iInBytes),
        .iInAad(iInAad), .iInLast(iInLast), .iInValid(iInValid), .oInReady(oInReady),
        .oInit(oInit), .iCoreReady(iCoreReady), .iCoreResultValid(iCoreResultValid),
        .iCoreTagValid(iCoreTagValid), .oAad(oAad), .oAad_valid(oAad_valid),
        .oAad_last(oAad_last), .oBlock(oBlock), .oBlock_valid(oBlock_valid),
        .oBlock_last(oBlock_last), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    // Stimulus for one message and observed pulse streams
    logic [0:127] ab_d[$], pb_d[$];
    int           ab_n[$], pb_n[$];
    bit           ab_l[$], pb_l[$];
    logic [129:0] aad_obs[$], blk_obs[$], aad_exp[$], blk_exp[$];
    logic         blk_last_prev = 1'b0;

    always @(negedge iClk) begin
        if (oAad_valid || oAad_last) aad_obs.push_back({oAad_last, oAad_valid, oAad});
        if (oBlock_valid || (oBlock_last && !blk_last_prev)) blk_obs.push_back({oBlock_last, oBlock_valid, oBlock});
        blk_last_prev <= oBlock_last;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:127] pad(input logic [0:127] d, input int n);
        logic [0:127] r;
        int m;
        r = '0;
        m = (n > 16) ? 16 : n;
        for (int k = 0; k < m; k++) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clr();
        ab_d.delete(); ab_n.delete(); ab_l.delete();
        pb_d.delete(); pb_n.delete(); pb_l.delete();
    endtask

    task automatic add_a(input logic [0:127] d, input int n, input bit l);
        ab_d.push_back(d); ab_n.push_back(n); ab_l.push_back(l);
    endtask

    task automatic add_p(input logic [0:127] d, input int n, input bit l);
        pb_d.push_back(d); pb_n.push_back(n); pb_l.push_back(l);
    endtask

    task automatic tick();
        @(posedge iClk); #1;
    endtask

    task automatic send(input logic [0:127] d, input int n, input bit aad, input bit last);
        iIn = d; iInBytes = 5'(n); iInAad = aad; iInLast = last; iInValid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge iClk);
            if (oInReady) break;
        end
        chk("in_ready", 128'(oInReady), 128'd1);
        @(posedge iClk); #1;
        iInValid = 1'b0;
    endtask

    task automatic wait_result(input int delay, input bit last, input bit wrong);
        for (int d = 0; d < delay; d++) begin
            @(negedge iClk);
            chk("wait_in_ready", 128'(oInReady), 128'd0);
            chk("wait_block_last", 128'(oBlock_last), 128'(last));
            if (wrong && d == 2) iStart = 1'b1;
            if (wrong && d == 3) iStart = 1'b0;
        end
        @(posedge iClk); #1; iCoreResultValid = 1'b1;
        tick(); iCoreResultValid = 1'b0;
    endtask

    task automatic run_msg(input int delay, input bit wrong);
        longint sa, sc;
        int m;
        sa = 0; sc = 0;
        aad_exp.delete(); blk_exp.delete();
        foreach (ab_d[i]) begin
            m = (ab_n[i] > 16) ? 16 : ab_n[i];
            sa += m;
            if (m > 0) aad_exp.push_back({ab_l[i], 1'b1, pad(ab_d[i], m)});
            else if (ab_l[i]) aad_exp.push_back({1'b1, 1'b0, 128'd0});
        end
        foreach (pb_d[i]) begin
            m = (pb_n[i] > 16) ? 16 : pb_n[i];
            sc += m;
            if (m > 0) blk_exp.push_back({pb_l[i], 1'b1, pad(pb_d[i], m)});
            else if (pb_l[i]) blk_exp.push_back({1'b1, 1'b0, 128'd0});
        end
        aad_obs.delete(); blk_obs.delete();

        iCoreReady = 1'b0;
        iStart = 1'b1; tick(); iStart = 1'b0;
        @(negedge iClk);
        chk("busy_start", {oBusy, oInit}, 2'b11);
        if (wrong) begin
            iIn = rnd128(); iInBytes = 5'd16; iInAad = 1'b0; iInLast = 1'b1; iInValid = 1'b1;
        end
        tick(); iCoreReady = 1'b1;
        if (wrong) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge iClk);
                chk("wrong_section_ready", 128'(oInReady), 128'd0);
            end
            iInValid = 1'b0;
            tick();
        end
        foreach (ab_d[i]) send(ab_d[i], ab_n[i], 1'b1, ab_l[i]);
        foreach (pb_d[i]) begin
            send(pb_d[i], pb_n[i], 1'b0, pb_l[i]);
            if (pb_n[i] != 0) wait_result(delay, pb_l[i], wrong);
        end
        tick(); tick();
        @(negedge iClk);
        chk("len_block", oAad, {64'(sa * 8), 64'(sc * 8)});
        chk("len_flags", {oAad_valid, oInReady, oBusy}, 3'b001);
        iCoreTagValid = 1'b1;
        @(posedge iClk); #1; iCoreTagValid = 1'b0;
        @(negedge iClk);
        chk("idle_after_tag", {oBusy, oInit}, 2'b00);

        chk("aad_count", 128'(aad_obs.size()), 128'(aad_exp.size()));
        chk("blk_count", 128'(blk_obs.size()), 128'(blk_exp.size()));
        for (int i = 0; i < aad_obs.size() && i < aad_exp.size(); i++) begin
            chk("aad_flags", 128'(aad_obs[i][129:128]), 128'(aad_exp[i][129:128]));
            if (aad_exp[i][128]) chk("aad_data", aad_obs[i][127:0], aad_exp[i][127:0]);
        end
        for (int i = 0; i < blk_obs.size() && i < blk_exp.size(); i++) begin
            chk("blk_flags", 128'(blk_obs[i][129:128]), 128'(blk_exp[i][129:128]));
            if (blk_exp[i][128]) chk("blk_data", blk_obs[i][127:0], blk_exp[i][127:0]);
        end
    endtask

    task automatic gen_random();
        int na, np;
        clr();
        na = $urandom_range(1, 3);
        np = $urandom_range(1, 3);
        for (int i = 0; i < na; i++) add_a(rnd128(), $urandom_range(0, 20), i == na - 1);
        for (int i = 0; i < np; i++) add_p(rnd128(), $urandom_range(0, 20), i == np - 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {oInReady, oInit, oAad_valid, oAad_last, oBlock_valid, oBlock_last, oBusy}, 7'd0);
        chk({tag, "_aad"}, oAad, 128'd0);
        chk({tag, "_block"}, oBlock, 128'd0);
    endtask

    initial begin
        iRstn = 1'b0; iStart = 1'b0; iIn = '0; iInBytes = '0; iInAad = 1'b0; iInLast = 1'b0;
        iInValid = 1'b0; iCoreReady = 1'b0; iCoreResultValid = 1'b0; iCoreTagValid = 1'b0;
        repeat (3) tick();
        @(negedge iClk);
        chk_all_zero("reset");
        iRstn = 1'b1;
        tick();

        // 1: empty AAD, one full payload block of 8'hAA
        clr();
        add_a(128'd0, 0, 1'b1);
        add_p({16{8'hAA}}, 16, 1'b1);
        run_msg(3, 1'b0);

        // 2: AAD 16 + 4 bytes, payload 13 bytes
        clr();
        add_a(rnd128(), 16, 1'b0);
        add_a(rnd128(), 4, 1'b1);
        add_p(rnd128(), 13, 1'b1);
        run_msg(2, 1'b0);

        // 3: AAD 16 bytes, empty payload
        clr();
        add_a(rnd128(), 16, 1'b1);
        add_p(rnd128(), 0, 1'b1);
        run_msg(2, 1'b0);

        // 4: three payload beats, slow core results
        clr();
        add_a(rnd128(), 9, 1'b1);
        add_p(rnd128(), 16, 1'b0);
        add_p(rnd128(), 16, 1'b0);
        add_p(rnd128(), 7, 1'b1);
        run_msg(12, 1'b0);

        // 5: reset during DATA_WAIT, then a normal message
        iCoreReady = 1'b1;
        iStart = 1'b1; tick(); iStart = 1'b0;
        send(rnd128(), 16, 1'b1, 1'b1);
        send(rnd128(), 16, 1'b0, 1'b1);
        repeat (3) tick();
        iRstn = 1'b0;
        tick();
        @(negedge iClk);
        chk_all_zero("abort");
        iRstn = 1'b1;
        tick();
        gen_random();
        run_msg(3, 1'b0);

        // 6: wrong-section beat during AAD, iStart during DATA_WAIT
        clr();
        add_a(rnd128(), 5, 1'b1);
        add_p(rnd128(), 11, 1'b1);
        run_msg(6, 1'b1);

        for (int r = 0; r < 8; r++) begin
            gen_random();
            run_msg($urandom_range(1, 6), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
